// File: rtl/lb_byte_bridge.sv
// Byte-stream to LocalBus bridge: parses 0x57 write / 0x52 read packets from the host
// receiver, issues single-cycle LocalBus strobes and returns read data as four bytes.
module lb_byte_bridge #(
    parameter logic [15:0] rd_timeout = 16'd255,
    parameter logic [15:0] rx_timeout = 16'd50000
) (
    input  logic        clk_lb,
    input  logic        reset_n,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        lb_wr,
    output logic        lb_rd,
    output logic [31:0] lb_addr,
    output logic [31:0] lb_wr_d,
    input  logic [31:0] lb_rd_d,
    input  logic        lb_rd_rdy,
    output logic        busy
);

    localparam logic [7:0]  CMD_WR  = 8'h57;
    localparam logic [7:0]  CMD_RD  = 8'h52;
    localparam logic [31:0] RD_FILL = 32'hDEAD_BEEF;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        WR,
        RD,
        RD_WAIT,
        TX
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        is_wr;
    logic [1:0]  byte_cnt;
    logic [1:0]  tx_cnt;
    logic [15:0] gap_cnt;
    logic [15:0] wait_cnt;
    logic [31:0] rd_shift;

    logic        rx_take;
    logic        rd_capture;
    logic        rd_expired;
    logic        tx_fire;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_nxt  = state;
        rx_take    = 1'b0;
        rd_capture = 1'b0;
        rd_expired = 1'b0;
        tx_fire    = 1'b0;

        case (state)
            IDLE: begin
                if (rx_valid && (rx_byte == CMD_WR || rx_byte == CMD_RD)) begin
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (rx_valid) begin
                    rx_take = 1'b1;
                    if (byte_cnt == 2'd3) begin
                        state_nxt = is_wr ? DATA : RD;
                    end
                end else if (gap_cnt == rx_timeout) begin
                    state_nxt = IDLE;
                end
            end
            DATA: begin
                if (rx_valid) begin
                    rx_take = 1'b1;
                    if (byte_cnt == 2'd3) begin
                        state_nxt = WR;
                    end
                end else if (gap_cnt == rx_timeout) begin
                    state_nxt = IDLE;
                end
            end
            WR: begin
                state_nxt = IDLE;
            end
            RD: begin
                state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                // Returned data wins over a timeout landing on the same edge.
                if (lb_rd_rdy) begin
                    rd_capture = 1'b1;
                    state_nxt  = TX;
                end else if (wait_cnt == rd_timeout) begin
                    rd_expired = 1'b1;
                    state_nxt  = TX;
                end
            end
            TX: begin
                if (tx_valid && tx_ready) begin
                    tx_fire = 1'b1;
                    if (tx_cnt == 2'd3) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_lb or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
            state <= state_nxt;
        end
    end

    // Strobes and status are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk_lb or negedge reset_n) begin
        if (!reset_n) begin
            lb_wr    <= 1'b0;
            lb_rd    <= 1'b0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            lb_wr    <= (state_nxt == WR);
            lb_rd    <= (state_nxt == RD);
            tx_valid <= (state_nxt == TX);
            busy     <= (state_nxt != IDLE);
        end
    end

    always_ff @(posedge clk_lb or negedge reset_n) begin
        if (!reset_n) begin
            is_wr    <= 1'b0;
            byte_cnt <= 2'd0;
            lb_addr  <= 32'd0;
            lb_wr_d  <= 32'd0;
        end else begin
            if (state == IDLE && state_nxt == ADDR) begin
                is_wr <= (rx_byte == CMD_WR);
            end
            // The 2-bit count wraps to zero after the 4th byte, ready for the next field.
            if (state == IDLE) begin
                byte_cnt <= 2'd0;
            end else if (rx_take) begin
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (rx_take && state == ADDR) begin
                lb_addr <= {lb_addr[23:0], rx_byte};
            end
            if (rx_take && state == DATA) begin
                lb_wr_d <= {lb_wr_d[23:0], rx_byte};
            end
        end
    end

    always_ff @(posedge clk_lb or negedge reset_n) begin
        if (!reset_n) begin
            gap_cnt  <= 16'd0;
            wait_cnt <= 16'd0;
        end else begin
            if (rx_valid || !(state == ADDR || state == DATA)) begin
                gap_cnt <= 16'd0;
            end else if (gap_cnt != CNT_MAX) begin
                gap_cnt <= gap_cnt + 16'd1;
            end
            if (state != RD_WAIT) begin
                wait_cnt <= 16'd0;
            end else if (wait_cnt != CNT_MAX) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_lb or negedge reset_n) begin
        if (!reset_n) begin
            rd_shift <= 32'd0;
            tx_cnt   <= 2'd0;
        end else begin
            if (rd_capture) begin
                rd_shift <= lb_rd_d;
            end else if (rd_expired) begin
                rd_shift <= RD_FILL;
            end else if (tx_fire) begin
                rd_shift <= {rd_shift[23:0], 8'h00};
            end
            if (state != TX) begin
                tx_cnt <= 2'd0;
            end else if (tx_fire) begin
                tx_cnt <= tx_cnt + 2'd1;
            end
        end
    end

    assign tx_byte = rd_shift[31:24];

endmodule

// File: tb/tb_lb_byte_bridge.sv
// Scoreboard bench for lb_byte_bridge: stimulus pushes expected LocalBus strobes and
// response bytes; independent monitors pop and compare whenever the bridge presents them.
module tb_lb_byte_bridge;

    localparam logic [15:0] RD_TO = 16'd8;
    localparam logic [15:0] RX_TO = 16'd20;

    logic        clk_lb;
    logic        reset_n;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic        lb_wr;
    logic        lb_rd;
    logic [31:0] lb_addr;
    logic [31:0] lb_wr_d;
    logic [31:0] lb_rd_d;
    logic        lb_rd_rdy;
    logic        busy;

    lb_byte_bridge #(
        .rd_timeout(RD_TO),
        .rx_timeout(RX_TO)
    ) dut (
        .clk_lb    (clk_lb),
        .reset_n   (reset_n),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .tx_byte   (tx_byte),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .lb_wr     (lb_wr),
        .lb_rd     (lb_rd),
        .lb_addr   (lb_addr),
        .lb_wr_d   (lb_wr_d),
        .lb_rd_d   (lb_rd_d),
        .lb_rd_rdy (lb_rd_rdy),
        .busy      (busy)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_wr[$];
    logic [31:0] exp_rd[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  stim_q[$];

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;
    int          tx_mode = 3;      // 0 ready high, 1 random, 2 held low, 3 follow tx_manual
    logic        tx_manual = 1'b0;
    int          resp_delay = 0;   // cycles after lb_rd to answer; 0 = never answer
    logic [31:0] resp_data = 32'd0;
    logic [31:0] cur_rd_addr = 32'd0;

    initial begin
        clk_lb = 1'b0;
        forever #5 clk_lb = ~clk_lb;
    end

    initial forever begin
        @(posedge clk_lb);
        cyc++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 400000", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Host-side transmitter acceptance
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk_lb);
            #1;
            case (tx_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = 1'($urandom_range(1, 0));
                2:       tx_ready = 1'b0;
                default: tx_ready = tx_manual;
            endcase
        end
    end

    // LocalBus read responder; also measures lb_rd -> tx_valid latency
    initial begin
        int unsigned r;
        int          want;
        int          guard;
        lb_rd_rdy = 1'b0;
        lb_rd_d   = 32'd0;
        forever begin
            @(negedge clk_lb);
            if (reset_n && lb_rd) begin
                r = cyc;
                if (resp_delay > 0) begin
                    repeat (resp_delay) @(posedge clk_lb);
                    #1;
                    lb_rd_rdy = 1'b1;
                    lb_rd_d   = resp_data;
                    check("rd_addr_stable", lb_addr, cur_rd_addr);
                    @(posedge clk_lb);
                    #1;
                    lb_rd_rdy = 1'b0;
                    lb_rd_d   = $urandom();
                    want = resp_delay + 1;
                end else begin
                    want = int'(RD_TO) + 2;
                end
                guard = 0;
                while (!tx_valid && guard < 400) begin
                    @(negedge clk_lb);
                    guard++;
                end
                check("rd_to_tx_latency", cyc - r, want);
            end
        end
    end

    // Scoreboard monitor
    initial begin
        wr_t         e;
        logic [31:0] a;
        logic [7:0]  b;
        forever begin
            @(negedge clk_lb);
            if (reset_n) begin
                if (lb_wr) begin
                    if (exp_wr.size() == 0) begin
                        check("wr_unexpected_strobe", 32'(lb_wr), 0);
                    end else begin
                        e = exp_wr.pop_front();
                        check("wr_addr", lb_addr, e.addr);
                        check("wr_data", lb_wr_d, e.data);
                    end
                end
                if (lb_rd) begin
                    if (exp_rd.size() == 0) begin
                        check("rd_unexpected_strobe", 32'(lb_rd), 0);
                    end else begin
                        a = exp_rd.pop_front();
                        check("rd_addr", lb_addr, a);
                    end
                end
                if (tx_valid && tx_ready) begin
                    if (exp_tx.size() == 0) begin
                        check("tx_unexpected_byte", 32'(tx_valid), 0);
                    end else begin
                        b = exp_tx.pop_front();
                        check("tx_byte", 32'(tx_byte), 32'(b));
                    end
                end
            end
        end
    end

    function automatic logic [31:0] read_model(input int delay, input logic [31:0] data);
        return (delay == 0) ? 32'hDEAD_BEEF : data;
    endfunction

    task automatic push_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) stim_q.push_back(w[8*i +: 8]);
    endtask

    task automatic send_stim(input int max_gap);
        int g;
        while (stim_q.size() > 0) begin
            @(posedge clk_lb);
            #1;
            rx_byte  = stim_q.pop_front();
            rx_valid = 1'b1;
            g = (stim_q.size() > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            if (g > 0) begin
                @(posedge clk_lb);
                #1;
                rx_valid = 1'b0;
                repeat (g - 1) @(posedge clk_lb);
            end
        end
        @(posedge clk_lb);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input int max_gap, input bit chk);
        wr_t e;
        e.addr = addr;
        e.data = data;
        exp_wr.push_back(e);
        stim_q.push_back(8'h57);
        push_word(addr);
        push_word(data);
        send_stim(max_gap);
        if (chk) begin
            @(negedge clk_lb);
            check("wr_strobe_latency", 32'(lb_wr), 1);
            check("wr_addr_at_strobe", lb_addr, addr);
            check("wr_data_at_strobe", lb_wr_d, data);
            check("wr_no_rd", 32'(lb_rd), 0);
            @(negedge clk_lb);
            check("wr_strobe_width", 32'(lb_wr), 0);
        end
    endtask

    task automatic issue_read(input logic [31:0] addr, input int delay,
                              input logic [31:0] data, input int max_gap);
        logic [31:0] resp;
        resp        = read_model(delay, data);
        resp_delay  = delay;
        resp_data   = data;
        cur_rd_addr = addr;
        exp_rd.push_back(addr);
        for (int i = 3; i >= 0; i--) exp_tx.push_back(resp[8*i +: 8]);
        stim_q.push_back(8'h52);
        push_word(addr);
        send_stim(max_gap);
        @(negedge clk_lb);
        check("rd_strobe_latency", 32'(lb_rd), 1);
    endtask

    task automatic wait_tx_valid(input string name);
        int n = 0;
        while (!tx_valid && n < 200) begin
            @(negedge clk_lb);
            n++;
        end
        check(name, 32'(tx_valid), 1);
    endtask

    task automatic wait_rd_done();
        int n = 0;
        while (exp_tx.size() != 0 && n < 2000) begin
            @(negedge clk_lb);
            n++;
        end
        check("rd_bytes_left", exp_tx.size(), 0);
        @(negedge clk_lb);
        check("rd_done_busy", 32'(busy), 0);
        check("rd_done_tx_valid", 32'(tx_valid), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_lb_wr"},    32'(lb_wr),    0);
        check({tag, "_lb_rd"},    32'(lb_rd),    0);
        check({tag, "_tx_valid"}, 32'(tx_valid), 0);
        check({tag, "_tx_byte"},  32'(tx_byte),  0);
        check({tag, "_busy"},     32'(busy),     0);
        check({tag, "_lb_addr"},  lb_addr,       0);
        check({tag, "_lb_wr_d"},  lb_wr_d,       0);
    endtask

    initial begin
        int  txv_seen;
        int  op;
        logic [31:0] a1;
        logic [31:0] a2;
        logic [31:0] d1;
        logic [31:0] d2;
        wr_t e;

        reset_n  = 1'b0;
        rx_byte  = 8'd0;
        rx_valid = 1'b0;
        repeat (3) @(posedge clk_lb);
        #1;
        check_reset_outputs("rst");
        @(posedge clk_lb);
        #1;
        reset_n = 1'b1;

        // Directed write
        tx_mode = 0;
        do_write(32'h0000_0000, 32'h1234_5678, 0, 1'b1);

        // Directed read, responder answers three cycles after lb_rd
        issue_read(32'h0000_0004, 3, 32'hA5C3_0F81, 0);
        wait_rd_done();

        // Read timeout: responder silent
        issue_read(32'h1000_0008, 0, 32'h0, 1);
        wait_rd_done();

        // Backpressure: ready held low, then toggled
        tx_mode = 2;
        issue_read(32'h2000_0010, 2, 32'h0BAD_CAFE, 1);
        wait_tx_valid("bp_tx_valid_rise");
        repeat (20) begin
            @(negedge clk_lb);
            check("bp_hold_byte", 32'(tx_byte), 32'(exp_tx[0]));
            check("bp_hold_valid", 32'(tx_valid), 1);
        end
        tx_mode = 1;
        wait_rd_done();

        // Resync: partial write dropped after inter-byte timeout, junk ignored, read completes
        tx_mode = 0;
        stim_q.push_back(8'h57);
        stim_q.push_back(8'h00);
        stim_q.push_back(8'h00);
        send_stim(0);
        repeat (int'(RX_TO)) @(posedge clk_lb);
        @(negedge clk_lb);
        check("gap_busy_before_expiry", 32'(busy), 1);
        @(posedge clk_lb);
        #1;
        rx_byte  = 8'h00;
        rx_valid = 1'b1;
        @(negedge clk_lb);
        check("gap_busy_after_expiry", 32'(busy), 0);
        @(posedge clk_lb);
        #1;
        rx_valid = 1'b0;
        issue_read(32'h3000_0020, 4, 32'h1357_9BDF, 0);
        wait_rd_done();

        // Back-to-back writes; a command byte landing in the WR cycle is lost
        a1 = $urandom();
        d1 = $urandom();
        a2 = $urandom();
        d2 = $urandom();
        e.addr = a1;
        e.data = d1;
        exp_wr.push_back(e);
        e.addr = a2;
        e.data = d2;
        exp_wr.push_back(e);
        stim_q.push_back(8'h57);
        push_word(a1);
        push_word(d1);
        stim_q.push_back(8'h52);
        stim_q.push_back(8'h57);
        push_word(a2);
        push_word(d2);
        send_stim(0);
        repeat (4) @(negedge clk_lb);
        check("b2b_writes_left", exp_wr.size(), 0);
        check("b2b_no_read", exp_rd.size(), 0);

        // Randomized packet mix
        for (int i = 0; i < 30; i++) begin
            op = int'($urandom_range(2, 0));
            if (op != 0) begin
                do_write($urandom(), $urandom(), int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
            end else begin
                tx_mode = int'($urandom_range(1, 0));
                issue_read($urandom(), int'($urandom_range(int'(RD_TO), 0)), $urandom(),
                           int'($urandom_range(3, 0)));
                wait_rd_done();
            end
        end
        repeat (4) @(negedge clk_lb);

        // Reset in the middle of the read response
        tx_mode   = 3;
        tx_manual = 1'b0;
        issue_read(32'h4000_0040, 2, 32'hC0DE_F00D, 0);
        wait_tx_valid("rst_tx_valid_rise");
        tx_manual = 1'b1;
        @(negedge clk_lb);
        @(negedge clk_lb);
        tx_manual = 1'b0;
        @(posedge clk_lb);
        #3;
        check("rst_two_bytes_sent", exp_tx.size(), 2);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midtx");
        exp_tx.delete();
        repeat (3) @(posedge clk_lb);
        #1;
        reset_n = 1'b1;
        tx_mode = 0;
        txv_seen = 0;
        repeat (30) begin
            @(negedge clk_lb);
            if (tx_valid) txv_seen++;
        end
        check("post_reset_no_tx", txv_seen, 0);
        check("post_reset_busy", 32'(busy), 0);

        check("end_wr_queue", exp_wr.size(), 0);
        check("end_rd_queue", exp_rd.size(), 0);
        check("end_tx_queue", exp_tx.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lb_byte_bridge.md
# lb_byte_bridge

Byte-stream-to-LocalBus command bridge that sits directly upstream of the SUMP2 core wrapper and acts as its only LocalBus master. It takes bytes from the host serial receiver and parses them into 32-bit write and read packets. It drives single-cycle `lb_wr`/`lb_rd` strobes with registered address and data, and returns read data to the serial transmitter as four bytes under a valid/ready handshake.

## Interface
Parameters:
- `rd_timeout`, 16'd255, number of `clk_lb` cycles to wait for `lb_rd_rdy` before substituting 32'hDEADBEEF.
- `rx_timeout`, 16'd50000, idle cycles allowed between bytes of one packet before the partial packet is dropped.

Ports:
- `clk_lb`  in  1  single clock for all logic.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rx_byte`  in  8  received byte.
- `rx_valid`  in  1  one-cycle strobe; `rx_byte` is valid this cycle.
- `tx_byte`  out  8  byte to transmit.
- `tx_valid`  out  1  `tx_byte` is valid.
- `tx_ready`  in  1  transmitter accepts the byte when `tx_valid` and `tx_ready` are both high at a rising edge.
- `lb_wr`  out  1  one-cycle write strobe.
- `lb_rd`  out  1  one-cycle read strobe.
- `lb_addr`  out  32  registered address.
- `lb_wr_d`  out  32  registered write data.
- `lb_rd_d`  in  32  read data, valid while `lb_rd_rdy` is high.
- `lb_rd_rdy`  in  1  read data valid strobe.
- `busy`  out  1  high in any state other than IDLE.

## Operation
Packet formats:
- Write: 0x57, then addr[31:24], [23:16], [15:8], [7:0], then data bytes in the same order, MSB first. Total 9 bytes.
- Read: 0x52, then 4 address bytes MSB first. Total 5 bytes. The response is 4 data bytes, MSB first.
- Any other byte received in IDLE is discarded; the state stays IDLE.

States:
- IDLE
  - On 0x57 or 0x52, latch the command and go to ADDR.
- ADDR
  - Shift each byte into `lb_addr`; a 2-bit counter counts the bytes.
  - After the 4th byte: write command goes to DATA, read command goes to RD.
- DATA
  - Shift each byte into `lb_wr_d`.
  - After the 4th byte, go to WR.
- WR
  - `lb_wr`=1 for exactly one cycle, then go to IDLE.
- RD
  - `lb_rd`=1 for exactly one cycle, then go to RD_WAIT.
- RD_WAIT
  - On `lb_rd_rdy`=1, capture `lb_rd_d` into a shift register and go to TX.
  - If the wait counter reaches `rd_timeout` first, load 32'hDEADBEEF and go to TX.
- TX
  - `tx_valid`=1 with `tx_byte`=shift[31:24].
  - On each handshake, shift left by 8 bits.
  - After the 4th handshake, `tx_valid`=0 and go to IDLE.

Rules:
- The inter-byte timer runs only in ADDR and DATA and clears on every `rx_valid`. When it reaches `rx_timeout`, go to IDLE: the packet is dropped and no strobe is issued. `lb_addr`/`lb_wr_d` keep their partial contents.
- `rx_valid` in WR, RD, RD_WAIT or TX is ignored and the byte is lost. The host must not send a new packet until it has received the read response.
- `lb_rd_rdy` outside RD_WAIT is ignored.
- `lb_addr` and `lb_wr_d` change only while bytes are shifted in. They are stable for the whole WR, RD and RD_WAIT phases.

## Timing
- All outputs are registered. On reset assertion they clear asynchronously: `lb_wr`=0, `lb_rd`=0, `lb_addr`=0, `lb_wr_d`=0, `tx_valid`=0, `tx_byte`=0, `busy`=0, state=IDLE. All counters clear.
- Reset asserted mid-packet or mid-TX aborts immediately. `tx_valid` falls without completing the handshake, and no response bytes are sent after reset is released.
- Write latency: `lb_wr` is high in the cycle after the edge that samples the 9th byte.
- Read latency: `lb_rd` is high in the cycle after the edge that samples the 5th byte. RD_WAIT starts one cycle after that.
- The edge that samples `lb_rd_rdy`=1 is followed by `tx_valid`=1 in the next cycle.
- With `lb_rd_rdy` never asserted, `tx_valid` rises `rd_timeout`+1 cycles after RD_WAIT entry.
- `tx_byte` is held constant while `tx_valid`=1 and `tx_ready`=0. With `tx_ready` held high, one byte goes out per cycle: 4 cycles.
- Back-to-back packets are allowed with no gap. A command byte arriving in the cycle WR returns to IDLE is lost; the first byte accepted is the one arriving one cycle later.
- Counter widths: wait and inter-byte counters are 16 bits and saturate, with no wrap.

## Test plan
- Write: send 57 00 00 00 00 12 34 56 78 -> exactly one `lb_wr` pulse, with `lb_addr`=0 and `lb_wr_d`=32'h12345678. `lb_rd` stays 0 throughout.
- Read: send 52 00 00 00 04, responder returns 32'hA5C3_0F81 three cycles after `lb_rd` -> `tx_byte` sequence A5, C3, 0F, 81. `busy` falls after the last handshake.
- Read timeout: `rd_timeout`=8, `lb_rd_rdy` held 0 -> `tx_valid` rises 9 cycles after RD_WAIT entry, and the bytes are DE, AD, BE, EF.
- Backpressure: hold `tx_ready` low for 20 cycles during TX -> `tx_byte` does not change. Toggling `tx_ready` yields exactly 4 accepted bytes with none duplicated.
- Resync: send 57 00 00, stall for `rx_timeout`+1 cycles, then send a valid read packet -> no `lb_wr` pulse, and the read completes normally. A leading 0x00 junk byte is ignored.
- Reset mid-TX: assert `reset_n`=0 after 2 bytes have been sent -> `tx_valid`=0 immediately and all outputs at their reset values. After release, no further response bytes are sent.
